cpu_garage_ram_arbiter: RTL

- Round-robin arbiter that shares the single data-RAM port among NUM_REQ CPU cores in cpu_garage.
- Each core issues one-word read or write commands (we / address / write data).
- The arbiter registers the winning command onto the RAM port, returns read data with a per-requester valid, and exposes ram_we / ram_address / ram_wdata for the memory-write tracker.

---
 rtl/cpu_garage_ram_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/cpu_garage_ram_arbiter.sv
// Round-robin arbiter sharing the single cpu_garage data-RAM port among NUM_REQ cores.
// The winning command is registered onto the RAM port; read data returns two cycles after the request.
module cpu_garage_ram_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_address,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic [CNT_W-1:0]          grant_cnt
);

    localparam int unsigned      PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] elig;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    int unsigned        scan_idx;

    // A core holding gnt this cycle is masked so it cannot be issued twice back-to-back.
    assign elig  = req & ~gnt;
    assign rdata = ram_rdata;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (32'(rr_ptr) + off) % NUM_REQ;
            if (!win_found && elig[PTR_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(scan_idx);
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(win_idx) == i) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            gnt         <= '0;
            rvalid      <= '0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            grant_cnt   <= '0;
            rr_ptr      <= PTR_RST;
        end else begin
            // The read command on the port this cycle has its data back next cycle.
            rvalid <= gnt & {NUM_REQ{~ram_we}};
            if (win_found) begin
                gnt         <= NUM_REQ'(1) << win_idx;
                ram_we      <= win_we;
                ram_address <= win_addr;
                ram_wdata   <= win_wdata;
                rr_ptr      <= win_idx;
                grant_cnt   <= grant_cnt + 1'b1;
            end else begin
                gnt    <= '0;
                ram_we <= 1'b0;
            end
        end
    end

endmodule
